// File: rtl/pid_step_sequencer.sv
// pid_step_sequencer: sample-rate scheduler and sequencer for the 8-bit PID
// datapath. Captures setpoint/feedback on a tick, evaluates P, I and D over
// successive cycles with one product per cycle, then sums, scales, saturates
// and presents an 8-bit control value with a one-cycle valid strobe.
// Optional build macro PID_ANTIWINDUP_EN clamps the integrator to +/-INT_LIM.
//
// state  | meaning
// IDLE   | waiting for a tick; err latched on acceptance
// CALC_P | p = KP*err
// CALC_I | integ += KI*err (clamped when anti-windup is built in)
// CALC_D | d = KD*(err - prev_err)
// SUM    | s = p + integ + d; saturated result registered into control_out
// OUT    | control_out/out_valid visible; prev_err <= err
module pid_step_sequencer #(
   parameter logic [7:0]         KP      = 8'd16,
   parameter logic [7:0]         KI      = 8'd2,
   parameter logic [7:0]         KD      = 8'd1,
   parameter logic [15:0]        DIV     = 16'd100,
   parameter int                 SHIFT   = 4,
   parameter logic signed [19:0] INT_LIM = 20'sd65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       sample_req,
   input  logic       clear,
   input  logic [7:0] setpoint,
   input  logic [7:0] feedback,
   output logic [7:0] control_out,
   output logic       out_valid,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic [2:0] {IDLE, CALC_P, CALC_I, CALC_D, SUM, OUT} state_t;

   state_t             state_q;
   logic [15:0]        cnt_q;
   logic signed [8:0]  err_q, prev_err_q;
   logic signed [16:0] p_q;
   logic signed [19:0] integ_q;
   logic signed [19:0] d_q;
   logic [7:0]         control_out_q;
   logic               out_valid_q, overrun_q;

   logic               tick_int, tick;
   logic signed [8:0]  err_d;
   logic signed [16:0] p_d;
   logic signed [19:0] prod_i, integ_d, d_d;
   logic signed [9:0]  diff;
   logic signed [21:0] s_d, sh;
   logic [7:0]         sat_d;

   // Prescaler: free-running 0..DIV-1 while enabled, parked at 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt_q <= 16'd0;
      else if (!enable)              cnt_q <= 16'd0;
      else if (cnt_q == DIV - 16'd1) cnt_q <= 16'd0;
      else                           cnt_q <= cnt_q + 16'd1;
   end

   assign tick_int = enable & (cnt_q == DIV - 16'd1);
   assign tick     = tick_int | sample_req;

   assign err_d  = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
   assign p_d    = $signed({9'd0, KP}) * $signed({{8{err_q[8]}}, err_q});
   assign prod_i = $signed({12'd0, KI}) * $signed({{11{err_q[8]}}, err_q});
   assign diff   = $signed({err_q[8], err_q}) - $signed({prev_err_q[8], prev_err_q});
   assign d_d    = $signed({12'd0, KD}) * $signed({{10{diff[9]}}, diff});
   assign s_d    = $signed({{5{p_q[16]}}, p_q}) + $signed({{2{integ_q[19]}}, integ_q})
                 + $signed({{2{d_q[19]}}, d_q});
   assign sh     = s_d >>> SHIFT;

`ifdef PID_ANTIWINDUP_EN
   // Integrator update evaluated one bit wider so the clamp sees the true sum.
   logic signed [20:0] integ_w;
   always_comb begin
      integ_w = $signed({integ_q[19], integ_q}) + $signed({prod_i[19], prod_i});
      if (integ_w > $signed({INT_LIM[19], INT_LIM}))
         integ_d = INT_LIM;
      else if (integ_w < -$signed({INT_LIM[19], INT_LIM}))
         integ_d = -INT_LIM;
      else
         integ_d = integ_w[19:0];
   end
`else
   assign integ_d = integ_q + prod_i;
`endif

   // Saturate the scaled sum into 0..255.
   always_comb begin
      sat_d = sh[7:0];
      if (sh[21])          sat_d = 8'd0;
      else if (|sh[20:8])  sat_d = 8'd255;
   end

   // Sequencer: one datapath step per state; clear aborts and wins over a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         err_q         <= '0;
         prev_err_q    <= '0;
         p_q           <= '0;
         integ_q       <= '0;
         d_q           <= '0;
         control_out_q <= 8'd0;
         out_valid_q   <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (clear) begin
            integ_q    <= '0;
            prev_err_q <= '0;
            state_q    <= IDLE;
         end else begin
            if (tick && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
               IDLE: if (tick) begin
                  err_q   <= err_d;
                  state_q <= CALC_P;
               end
               CALC_P: begin
                  p_q     <= p_d;
                  state_q <= CALC_I;
               end
               CALC_I: begin
                  integ_q <= integ_d;
                  state_q <= CALC_D;
               end
               CALC_D: begin
                  d_q     <= d_d;
                  state_q <= SUM;
               end
               SUM: begin
                  control_out_q <= sat_d;
                  out_valid_q   <= 1'b1;
                  state_q       <= OUT;
               end
               OUT: begin
                  prev_err_q <= err_q;
                  state_q    <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign control_out = control_out_q;
   assign out_valid   = out_valid_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pid_step_sequencer.sv
// Bench for pid_step_sequencer: reference model pushes expected control
// values into a queue; a monitor pops and compares on every out_valid.
module tb_pid_step_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       sample_req = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] setpoint = 8'd0;
   logic [7:0] feedback = 8'd0;
   logic [7:0] control_out;
   logic       out_valid, busy, overrun;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int n_valid = 0;
   int q[$];
   int vt[$];
   int m_integ = 0;
   int m_prev = 0;

   pid_step_sequencer #(
      .KP(8'd16), .KI(8'd2), .KD(8'd1), .DIV(16'd8), .SHIFT(4), .INT_LIM(20'sd100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sample_req(sample_req),
      .clear(clear), .setpoint(setpoint), .feedback(feedback),
      .control_out(control_out), .out_valid(out_valid), .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference PID step: returns the expected saturated output.
   function automatic int model(input int sp, input int fb);
      int e, p, d, s, sh;
      e = sp - fb;
      p = 16 * e;
      m_integ = m_integ + 2 * e;
`ifdef PID_ANTIWINDUP_EN
      if (m_integ > 100)  m_integ = 100;
      if (m_integ < -100) m_integ = -100;
`else
      m_integ = (m_integ <<< 12) >>> 12;
`endif
      d = e - m_prev;
      m_prev = e;
      s = p + m_integ + d;
      sh = s >>> 4;
      if (sh < 0)   return 0;
      if (sh > 255) return 255;
      return sh;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         n_valid++;
         vt.push_back(cyc);
         if (q.size() == 0) chk("unexpected_valid", 1, 0);
         else chk("control_out", control_out, q.pop_front());
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      sample_req = 1'b0;
      clear = 1'b0;
      enable = 1'b0;
      m_integ = 0;
      m_prev = 0;
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Entered and left at posedge+1 with the DUT idle.
   task automatic run_sample(input int sp, input int fb, input bit lat);
      setpoint = 8'(sp);
      feedback = 8'(fb);
      sample_req = 1'b1;
      q.push_back(model(sp, fb));
      @(posedge clk);
      #1 sample_req = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (lat) begin
            chk("busy_window", busy, 1);
            chk("valid_latency", out_valid, (i == 5) ? 1 : 0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nv0;
      bit done;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_control_out", control_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      do_reset();

      // basic step, then the same inputs again (integrator grows, d=0)
      run_sample(100, 90, 1);
      chk("idle_after_out", busy, 0);
      run_sample(100, 90, 1);

      // negative saturation and positive saturation
      do_reset();
      run_sample(0, 200, 1);
      do_reset();
      run_sample(255, 0, 1);

      // tick two cycles after acceptance is dropped with an overrun pulse
      do_reset();
      nv0 = n_valid;
      setpoint = 8'd100; feedback = 8'd90;
      sample_req = 1'b1;
      q.push_back(model(100, 90));
      @(posedge clk); #1 sample_req = 1'b0;
      @(posedge clk); #1 sample_req = 1'b1;
      @(posedge clk); #1 sample_req = 1'b0;
      @(negedge clk); chk("overrun_pulse", overrun, 1);
      @(negedge clk); chk("overrun_single", overrun, 0);
      repeat (10) @(posedge clk);
      #1 chk("one_valid_on_overrun", n_valid - nv0, 1);

      // clear during CALC_D aborts with no output
      do_reset();
      nv0 = n_valid;
      setpoint = 8'd100; feedback = 8'd90;
      sample_req = 1'b1;
      @(posedge clk); #1 sample_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      chk("clear_abort_busy", busy, 0);
      repeat (8) @(posedge clk);
      #1 chk("clear_no_valid", n_valid - nv0, 0);
      chk("clear_keeps_output", control_out, 0);
      run_sample(100, 90, 1);

      // clear together with a tick in IDLE: tick dropped, no overrun
      clear = 1'b1; sample_req = 1'b1;
      @(posedge clk); #1 clear = 1'b0; sample_req = 1'b0;
      m_integ = 0; m_prev = 0;
      chk("clear_tick_busy", busy, 0);
      @(negedge clk); chk("clear_tick_overrun", overrun, 0);
      @(posedge clk); #1;
      run_sample(100, 90, 1);

      // asynchronous reset mid-computation
      sample_req = 1'b1;
      @(posedge clk); #1 sample_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #1 chk("async_rst_busy", busy, 0);
      do_reset();

      // internal prescaler, DIV=8
      setpoint = 8'd100; feedback = 8'd90;
      for (int i = 0; i < 4; i++) q.push_back(model(100, 90));
      vt.delete();
      enable = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         @(negedge clk);
         if (vt.size() >= 4) done = 1'b1;
      end
      @(posedge clk); #1 enable = 1'b0;
      chk("presc_valid_count", (vt.size() >= 4) ? 4 : vt.size(), 4);
      for (int i = 1; i < 4 && i < vt.size(); i++)
         chk("presc_spacing", vt[i] - vt[i-1], 8);
      repeat (12) @(posedge clk);
      #1 chk("presc_queue_drained", q.size(), 0);

      // windup then zero error exposes the integrator value
      do_reset();
      for (int i = 0; i < 4; i++) run_sample(255, 0, 0);
      run_sample(128, 128, 0);
      run_sample(128, 128, 0);
      repeat (3) @(posedge clk);
      #1 chk("final_queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
